// File: rtl/jkff_pkg.sv
// Shared {j,k} command encodings and the per-lane next-state rule for jkff.
// Latency: none (constants and a pure function only).
// Backpressure: not applicable; nothing here holds state.
//
// Contents:
//   JK_HOLD/JK_RST/JK_SET/JK_TGL : 2-bit encodings of the {j,k} pair
//   jk_next()                    : next value of one lane given {j,k} and current q
package jkff_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // Next state of a single lane. The default arm keeps the current value;
  // it is only reachable with X/Z on j or k, where the result is don't-care.
  function automatic logic jk_next(input logic [1:0] jk, input logic cur_q);
    logic nxt;
    nxt = cur_q;
    case (jk)
      JK_HOLD: nxt = cur_q;
      JK_RST:  nxt = 1'b0;
      JK_SET:  nxt = 1'b1;
      JK_TGL:  nxt = ~cur_q;
      default: nxt = cur_q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jkff_cell.sv
// Single-bit JK flip-flop with synchronous active-high reset and a per-cell reset value.
// Latency: j/k/reset sampled on a rising edge of clk appear on q right after that edge.
// Backpressure: none; the cell updates on every clock edge.
//
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, wins over j/k
//   j, k  : set / reset controls (both high toggles)
//   q     : registered state
module jkff_cell
  import jkff_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  logic       r_q;
  logic [1:0] w_jk;

  assign w_jk = {j, k};

  // Reset is checked first so a pending J/K action on the same edge is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= RESET_VAL;
    end else begin
      r_q <= jk_next(w_jk, r_q);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/jkff.sv
// WIDTH independent JK flip-flop lanes with synchronous reset to RESET_VAL.
// Latency: one clk; qn is a plain inversion of q and adds no latency.
// Backpressure: none; every lane updates on every rising edge.
//
// Ports:
//   clk   : rising-edge clock, the only clock in the block
//   reset : synchronous active-high reset, loads RESET_VAL into q
//   j, k  : per-lane set / reset controls, WIDTH bits each
//   q     : registered state, WIDTH bits
//   qn    : ~q, WIDTH bits
// WIDTH must be at least 1.
module jkff #(
  parameter int                 WIDTH     = 1,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn
);

  logic [WIDTH-1:0] w_q;

  // Lanes share only clk and reset; there is no cross-lane logic.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    jkff_cell #(
      .RESET_VAL (RESET_VAL[i])
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .j     (j[i]),
      .k     (k[i]),
      .q     (w_q[i])
    );
  end

  assign q  = w_q;
  assign qn = ~w_q;

endmodule

// File: tb/tb_jkff.sv
module tb_jkff;

  logic clk;

  // Single-lane instance, default parameters
  logic       rst1, j1, k1;
  logic       q1, qn1;
  // Four lanes, RESET_VAL = 4'b1010
  logic       rst4;
  logic [3:0] j4, k4, q4, qn4;
  // Eight lanes, RESET_VAL = 8'h3C, used for randomized checking
  logic       rst8;
  logic [7:0] j8, k8, q8, qn8;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [3:0] RV4 = 4'b1010;
  localparam logic [7:0] RV8 = 8'h3C;

  jkff u_dut1 (
    .clk(clk), .reset(rst1), .j(j1), .k(k1), .q(q1), .qn(qn1)
  );

  jkff #(.WIDTH(4), .RESET_VAL(RV4)) u_dut4 (
    .clk(clk), .reset(rst4), .j(j4), .k(k4), .q(q4), .qn(qn4)
  );

  jkff #(.WIDTH(8), .RESET_VAL(RV8)) u_dut8 (
    .clk(clk), .reset(rst8), .j(j8), .k(k8), .q(q8), .qn(qn8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait for a rising edge and settle 1 ns past it before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: characteristic equation Q+ = J&~Q | ~K&Q, applied to all lanes at once.
  function automatic logic [7:0] ref_next(input logic [7:0] jj, input logic [7:0] kk,
                                          input logic [7:0] qq);
    return (jj & ~qq) | (~kk & qq);
  endfunction

  task automatic test_reset();
    rst1 = 1'b1; j1 = 1'b0; k1 = 1'b0;
    tick();                              // edge at 5 ns
    n_vec++;
    if (q1 !== 1'b0) begin
      n_err++; $display("FAIL reset_q: got %b want 0", q1);
    end
    n_vec++;
    if (qn1 !== 1'b1) begin
      n_err++; $display("FAIL reset_qn: got %b want 1", qn1);
    end
    #6;                                  // 12 ns
    rst1 = 1'b0;
  endtask

  task automatic test_sequence();
    logic [1:0] jk_seq [6];
    logic       q_exp  [6];
    jk_seq = '{2'b10, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10};
    q_exp  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int s = 0; s < 6; s++) begin
      {j1, k1} = jk_seq[s];
      tick();
      n_vec++;
      if (q1 !== q_exp[s] || qn1 !== ~q_exp[s]) begin
        n_err++;
        $display("FAIL seq_step%0d: got q=%b qn=%b want q=%b", s, q1, qn1, q_exp[s]);
      end
    end
  endtask

  task automatic test_reset_priority();
    // q is 1 on entry
    rst1 = 1'b1; j1 = 1'b1; k1 = 1'b0;
    tick();
    n_vec++;
    if (q1 !== 1'b0) begin
      n_err++; $display("FAIL rst_prio: got %b want 0", q1);
    end
    rst1 = 1'b0; j1 = 1'b1; k1 = 1'b1;
    tick();
    n_vec++;
    if (q1 !== 1'b1) begin
      n_err++; $display("FAIL rst_release_toggle: got %b want 1", q1);
    end
  endtask

  task automatic test_div2();
    logic prev;
    j1 = 1'b0; k1 = 1'b1;
    tick();
    n_vec++;
    if (q1 !== 1'b0) begin
      n_err++; $display("FAIL div2_clear: got %b want 0", q1);
    end
    prev = 1'b0;
    j1 = 1'b1; k1 = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      n_vec++;
      // Expected pattern 1,0,1,0,...; each edge must flip q, giving a 2-clk period.
      if (q1 !== ((e % 2 == 0) ? 1'b1 : 1'b0) || q1 === prev) begin
        n_err++;
        $display("FAIL div2_edge%0d: got %b want %b", e, q1, (e % 2 == 0) ? 1'b1 : 1'b0);
      end
      prev = q1;
    end
  endtask

  task automatic test_between_edges();
    logic q_before;
    j1 = 1'b0; k1 = 1'b0;
    tick();
    q_before = q1;
    #2;  j1 = 1'b1;                      // pulse lives well clear of both edges
    #3;  j1 = 1'b0;
    tick();
    n_vec++;
    if (q1 !== q_before) begin
      n_err++; $display("FAIL between_edges: got %b want %b", q1, q_before);
    end
  endtask

  task automatic test_lanes();
    rst4 = 1'b1; j4 = 4'b0000; k4 = 4'b0000;
    tick();
    n_vec++;
    if (q4 !== 4'b1010 || qn4 !== 4'b0101) begin
      n_err++; $display("FAIL lanes_reset: got q=%b qn=%b want q=1010", q4, qn4);
    end
    rst4 = 1'b0; j4 = 4'b0101; k4 = 4'b0011;
    tick();
    n_vec++;
    if (q4 !== 4'b1101 || qn4 !== 4'b0010) begin
      n_err++; $display("FAIL lanes_mixed: got q=%b qn=%b want q=1101", q4, qn4);
    end
  endtask

  task automatic test_random_w8();
    logic [7:0] m;
    rst8 = 1'b1; j8 = $urandom; k8 = $urandom;
    tick();
    m = RV8;
    n_vec++;
    if (q8 !== m) begin
      n_err++; $display("FAIL rand8_reset: got %h want %h", q8, m);
    end
    for (int c = 0; c < 300; c++) begin
      rst8 = ($urandom_range(0, 15) == 0);
      j8   = 8'($urandom);
      k8   = 8'($urandom);
      m    = rst8 ? RV8 : ref_next(j8, k8, m);
      tick();
      n_vec++;
      if (q8 !== m || qn8 !== ~m) begin
        n_err++;
        $display("FAIL rand8_cyc%0d: got q=%h qn=%h want q=%h", c, q8, qn8, m);
      end
    end
  endtask

  task automatic test_random_w1();
    logic [7:0] m;
    rst1 = 1'b1; j1 = 1'b0; k1 = 1'b0;
    tick();
    m = 8'h00;
    for (int c = 0; c < 200; c++) begin
      rst1 = ($urandom_range(0, 19) == 0);
      j1   = 1'($urandom);
      k1   = 1'($urandom);
      m    = rst1 ? 8'h00 : ref_next({7'b0, j1}, {7'b0, k1}, m);
      tick();
      n_vec++;
      if (q1 !== m[0] || qn1 !== ~m[0]) begin
        n_err++;
        $display("FAIL rand1_cyc%0d: got q=%b qn=%b want q=%b", c, q1, qn1, m[0]);
      end
    end
    rst1 = 1'b0;
  endtask

  initial begin
    rst1 = 1'b0; j1 = 1'b0; k1 = 1'b0;
    rst4 = 1'b0; j4 = '0;   k4 = '0;
    rst8 = 1'b0; j8 = '0;   k8 = '0;
    test_reset();
    test_sequence();
    test_reset_priority();
    test_div2();
    test_between_edges();
    test_lanes();
    test_random_w8();
    test_random_w1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
